mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore-style control FSM for the multicycle MIPS datapath. It sequences a single shared
//  instruction/data memory, the register file, the ALU and the PC. Supported instructions:
//  ADD, SUB, AND, OR, SLT, LW, SW, BEQ, ADDI and J.
//  Memory accesses use a req/ready handshake, so the memory may be slow.
//  Also maintains a retired-instruction counter and flags illegal instructions.
// PARAMETERS
//  CNT_W   32   width of instr_count (wraps modulo 2**CNT_W)
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  opcode         in   6      Instr[31:26] from instruction register
//  funct          in   6      Instr[5:0] from instruction register
//  zero           in   1      ALU Zero flag
//  mem_ready      in   1      memory completes the current access this cycle
//  mem_req        out  1      memory access request
//  mem_write      out  1      write strobe; valid only with mem_req
//  i_or_d         out  1      0 = address from PC; 1 = address from ALUOut
//  ir_write       out  1      load instruction register
//  pc_en          out  1      load PC
//  pc_src         out  2      00 = ALUResult; 01 = ALUOut; 10 = jump target
//  alu_src_a      out  1      0 = PC; 1 = ReadData1
//  alu_src_b      out  2      00 = ReadData2; 01 = 4; 10 = SignImm; 11 = SignImm<<2
//  alu_control    out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  reg_write      out  1      register file write enable
//  reg_dst        out  1      0 = rt; 1 = rd
//  mem_to_reg     out  1      0 = ALUOut; 1 = memory data
//  state          out  4      current state (debug)
//  instr_count    out  CNT_W  retired instructions
//  illegal_instr  out  1      one-cycle pulse on an unsupported opcode or funct
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE and instr_count=0.
//    All outputs are 0 in IDLE; alu_control is 010.
//  - State codes: 0 IDLE, 1 FETCH, 2 DECODE, 3 MEMADR, 4 MEMRD, 5 MEMWB, 6 MEMWR,
//    7 EXEC, 8 ALUWB, 9 BRANCH, 10 ADDIEX, 11 ADDIWB, 12 JUMP.
//  - Unlisted controls are 0 in every state; alu_control defaults to 010.
//  - Per-state transitions and outputs:
//    - IDLE   -> FETCH unconditionally.
//    - FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, pc_src=00.
//      Stays in FETCH while mem_ready=0.
//      On mem_ready=1: ir_write=1 and pc_en=1 (same cycle), then -> DECODE.
//    - DECODE: alu_src_b=11, add; ALUOut captures the branch target.
//      Next state by opcode:
//      - LW/SW (100011/101011) -> MEMADR
//      - R-type (000000) with funct in {100000,100010,100100,100101,101010} -> EXEC
//      - BEQ (000100) -> BRANCH
//      - ADDI (001000) -> ADDIEX
//      - J (000010) -> JUMP
//      - anything else -> FETCH, with illegal_instr=1 for this cycle and no count.
//    - MEMADR/ADDIEX: alu_src_a=1, alu_src_b=10, add.
//      MEMADR -> MEMRD (LW) or MEMWR (SW); ADDIEX -> ADDIWB.
//    - MEMRD: mem_req=1, i_or_d=1. Holds while mem_ready=0; -> MEMWB on ready.
//    - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//    - MEMWR: mem_req=1, mem_write=1, i_or_d=1, all held until mem_ready=1 -> FETCH.
//    - EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct
//      (add 010, sub 110, and 000, or 001, slt 111) -> ALUWB.
//    - ALUWB: reg_write=1, reg_dst=1 -> FETCH.
//    - ADDIWB: reg_write=1, reg_dst=0 -> FETCH.
//    - BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero -> FETCH.
//    - JUMP: pc_src=10, pc_en=1 -> FETCH.
//  - Latency in cycles, with zero-wait memory:
//    - LW 5 (plus FETCH and MEMRD waits)
//    - SW 4
//    - R-type 4
//    - ADDI 4
//    - BEQ 3
//    - J 3
//  - instr_count increments by 1 on the final cycle of each instruction.
//    Final cycles: MEMWB, MEMWR with mem_ready, ALUWB, ADDIWB, BRANCH, JUMP.
//    A BEQ counts whether or not the branch is taken.
//    All-ones wraps to 0.
//  - mem_ready is ignored in states without mem_req.
//  - Reset asserted mid-access: mem_req and mem_write drop immediately
//    (asynchronously), no increment occurs, and the FSM restarts from IDLE.
// TESTING
//  1. Reset, then ADD (funct 100000) with mem_ready held 1:
//     states 0,1,2,7,8,1; ALUWB has reg_write=1, reg_dst=1; instr_count=1.
//  2. LW with mem_ready low for 3 cycles in MEMRD:
//     MEMRD held 4 cycles with i_or_d=1; MEMWB has mem_to_reg=1; total 8 cycles.
//  3. SW with mem_ready delayed 2 cycles:
//     mem_write=1 for 3 cycles; count increments only on the ready cycle.
//  4. BEQ with zero=1 -> pc_en=1, pc_src=01; with zero=0 -> pc_en=0.
//     Both cases increment instr_count.
//  5. opcode 111111 or R-type funct 000000:
//     DECODE -> FETCH, illegal_instr pulses once, count unchanged.
//  6. CNT_W=4 with 16 ADDIs -> count wraps to 0.
//     Separately, rst_n=0 asserted during MEMWR -> mem_write=0 at once, state=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Sequences shared memory, register file, ALU and PC, and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_instr
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur_state;
    state_t next_state;
    logic   funct_ok;
    logic   retire;

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state    = cur_state;
        illegal_instr = 1'b0;
        unique case (cur_state)
            IDLE: next_state = FETCH;
            FETCH: begin
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            next_state = EXEC;
                        end else begin
                            next_state    = FETCH;
                            illegal_instr = 1'b1;
                        end
                    end
                    default: begin
                        next_state    = FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: next_state = FETCH;
            MEMWR: begin
                if (mem_ready) next_state = FETCH;
            end
            EXEC:   next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            ADDIEX: next_state = ADDIWB;
            ADDIWB: next_state = FETCH;
            JUMP:   next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Outputs depend only on the current state, except the handshake-qualified
    // strobes in FETCH and the zero-qualified branch enable.
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        unique case (cur_state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ADDIWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = zero;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (cur_state)
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: retire = 1'b1;
            MEMWR: retire = mem_ready;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: expected state traces are built per
// instruction class and wait counts, then compared cycle by cycle.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;

    logic        mem_req, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0]  pc_src, alu_src_b;
    logic        alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_instr;
    logic [2:0]  alu_control;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic        s_mem_req, s_mem_write, s_i_or_d, s_ir_write, s_pc_en;
    logic [1:0]  s_pc_src, s_alu_src_b;
    logic        s_alu_src_a, s_reg_write, s_reg_dst, s_mem_to_reg, s_illegal;
    logic [2:0]  s_alu_control;
    logic [3:0]  s_state;
    logic [3:0]  s_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] cnt = '0;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       z;
    } ent_t;
    ent_t plan[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .state(state), .instr_count(instr_count),
        .illegal_instr(illegal_instr)
    );

    mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(s_mem_req),
        .mem_write(s_mem_write), .i_or_d(s_i_or_d), .ir_write(s_ir_write),
        .pc_en(s_pc_en), .pc_src(s_pc_src), .alu_src_a(s_alu_src_a),
        .alu_src_b(s_alu_src_b), .alu_control(s_alu_control),
        .reg_write(s_reg_write), .reg_dst(s_reg_dst),
        .mem_to_reg(s_mem_to_reg), .state(s_state),
        .instr_count(s_count), .illegal_instr(s_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd8 || op == 6'd2)
            return 1'b1;
        if (op == 6'd0)
            return fn == 6'd32 || fn == 6'd34 || fn == 6'd36 ||
                   fn == 6'd37 || fn == 6'd42;
        return 1'b0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        if (fn == 6'd34) return 3'b110;
        if (fn == 6'd36) return 3'b000;
        if (fn == 6'd37) return 3'b001;
        if (fn == 6'd42) return 3'b111;
        return 3'b010;
    endfunction

    // Control word expected in each named step, taken from the state table.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                             input logic z, input logic [5:0] op,
                                             input logic [5:0] fn);
        logic mr, mw, iod, irw, pce, asa, rw, rd, mtr, ill;
        logic [1:0] ps, asb;
        logic [2:0] ac;
        {mr, mw, iod, irw, pce, asa, rw, rd, mtr, ill} = '0;
        ps = 2'b00; asb = 2'b00; ac = 3'b010;
        case (st)
            4'd1: begin mr = 1; asb = 2'b01; irw = rdy; pce = rdy; end
            4'd2: begin asb = 2'b11; ill = !legal(op, fn); end
            4'd3, 4'd10: begin asa = 1; asb = 2'b10; end
            4'd4: begin mr = 1; iod = 1; end
            4'd5: begin rw = 1; mtr = 1; end
            4'd6: begin mr = 1; mw = 1; iod = 1; end
            4'd7: begin asa = 1; ac = alu_of(fn); end
            4'd8: begin rw = 1; rd = 1; end
            4'd9: begin asa = 1; ac = 3'b110; ps = 2'b01; pce = z; end
            4'd11: rw = 1;
            4'd12: begin ps = 2'b10; pce = 1; end
            default: ;
        endcase
        return {mr, mw, iod, irw, pce, ps, asa, asb, ac, rw, rd, mtr, ill};
    endfunction

    task automatic cycle_check(input logic [3:0] st, input logic rdy,
                               input logic z);
        logic [16:0] obs;
        mem_ready = rdy;
        zero = z;
        #1;
        obs = {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, alu_control, reg_write, reg_dst, mem_to_reg,
               illegal_instr};
        check("state", 64'(state), 64'(st));
        check("ctrl", 64'(obs), 64'(exp_ctrl(st, rdy, z, opcode, funct)));
        check("count", 64'(instr_count), 64'(cnt));
        check("count4", 64'(s_count), 64'(cnt[3:0]));
        if (st == 4'd5 || st == 4'd8 || st == 4'd11 || st == 4'd9 ||
            st == 4'd12 || (st == 4'd6 && rdy))
            cnt = cnt + 1;
    endtask

    task automatic push(input logic [3:0] st, input int waits, input logic z);
        for (int k = 0; k < waits; k++) plan.push_back('{st, 1'b0, z});
        plan.push_back('{st, 1'b1, z});
    endtask

    task automatic push1(input logic [3:0] st, input logic z);
        plan.push_back('{st, 1'($urandom_range(0, 1)), z});
    endtask

    // One instruction: expected step sequence from its class and memory waits.
    // abort_wr >= 0 asserts reset that many cycles into the MEMWR wait.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic bz,
                             input int abort_wr);
        int wr_seen;
        plan.delete();
        push(4'd1, fw, 1'($urandom_range(0, 1)));
        push1(4'd2, 1'($urandom_range(0, 1)));
        if (legal(op, fn)) begin
            case (op)
                6'd35: begin
                    push1(4'd3, 1'($urandom_range(0, 1)));
                    push(4'd4, mw, 1'($urandom_range(0, 1)));
                    push1(4'd5, 1'($urandom_range(0, 1)));
                end
                6'd43: begin
                    push1(4'd3, 1'($urandom_range(0, 1)));
                    push(4'd6, mw, 1'($urandom_range(0, 1)));
                end
                6'd4: push1(4'd9, bz);
                6'd8: begin
                    push1(4'd10, 1'($urandom_range(0, 1)));
                    push1(4'd11, 1'($urandom_range(0, 1)));
                end
                6'd2: push1(4'd12, 1'($urandom_range(0, 1)));
                default: begin
                    push1(4'd7, 1'($urandom_range(0, 1)));
                    push1(4'd8, 1'($urandom_range(0, 1)));
                end
            endcase
        end
        wr_seen = 0;
        foreach (plan[i]) begin
            @(negedge clk);
            if (i == 0) begin
                opcode = op;
                funct = fn;
            end
            cycle_check(plan[i].st, plan[i].rdy, plan[i].z);
            if (plan[i].st == 4'd6) begin
                if (abort_wr >= 0 && wr_seen == abort_wr) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_mem_write", 64'(mem_write), 64'd0);
                    check("rst_mem_req", 64'(mem_req), 64'd0);
                    check("rst_state", 64'(state), 64'd0);
                    check("rst_count", 64'(instr_count), 64'd0);
                    cnt = '0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    cycle_check(4'd0, 1'b0, 1'b0);
                    return;
                end
                wr_seen++;
            end
        end
    endtask

    task automatic run_random();
        int kind;
        logic [5:0] op, fn;
        logic [5:0] rfn[5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        kind = $urandom_range(0, 7);
        fn = 6'($urandom);
        case (kind)
            0: op = 6'd0;
            1: op = 6'd35;
            2: op = 6'd43;
            3: op = 6'd4;
            4: op = 6'd8;
            5: op = 6'd2;
            6: begin
                op = 6'd0;
                while (legal(op, fn)) fn = 6'($urandom);
            end
            default: begin
                op = 6'($urandom);
                while (legal(op, fn) || op == 6'd0) op = 6'($urandom);
            end
        endcase
        if (kind == 0) fn = rfn[$urandom_range(0, 4)];
        run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), -1);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        cycle_check(4'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle_check(4'd0, 1'b0, 1'b0);

        run_instr(6'd0, 6'd32, 0, 0, 1'b0, -1);
        run_instr(6'd35, 6'd0, 0, 3, 1'b0, -1);
        run_instr(6'd43, 6'd0, 0, 2, 1'b0, -1);
        run_instr(6'd4, 6'd0, 0, 0, 1'b1, -1);
        run_instr(6'd4, 6'd0, 1, 0, 1'b0, -1);
        run_instr(6'd63, 6'd32, 0, 0, 1'b0, -1);
        run_instr(6'd0, 6'd0, 0, 0, 1'b0, -1);
        run_instr(6'd0, 6'd34, 0, 0, 1'b0, -1);
        run_instr(6'd0, 6'd42, 0, 0, 1'b0, -1);
        run_instr(6'd2, 6'd0, 0, 0, 1'b0, -1);
        for (int i = 0; i < 16; i++)
            run_instr(6'd8, 6'($urandom), 0, 0, 1'b0, -1);
        for (int i = 0; i < 300; i++) run_random();
        run_instr(6'd43, 6'd0, 0, 4, 1'b0, 1);
        for (int i = 0; i < 20; i++) run_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
